// File: rtl/pd_pkg.sv
// ----------------------------------------------------------------------------
// pd_pkg
// Shared definitions for the sequential 2-to-4 priority decoder.
//   state_t : decoder FSM states (IDLE, HOLD, GAP)
//   CODE_W  : width of the encoded index
//   LINES   : number of decoded output lines
//   onehot4 : maps a 2-bit code to its one-hot 4-bit line pattern
// ----------------------------------------------------------------------------
package pd_pkg;

    localparam int CODE_W = 2;
    localparam int LINES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [LINES-1:0] onehot4(input logic [CODE_W-1:0] code);
        logic [LINES-1:0] lines;
        lines       = '0;
        lines[code] = 1'b1;
        return lines;
    endfunction

endpackage

// File: rtl/dec_hold_counter_v.sv
// ----------------------------------------------------------------------------
// dec_hold_counter_v
// Loadable down-counter with a zero flag. Times both the HOLD and the GAP
// phases of the decoder. Load has priority over decrement.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (count clears to 0)
//   load     in   load load_val on the next edge
//   load_val in   value to load (CW bits)
//   dec      in   decrement on the next edge (must not be used at zero)
//   zero     out  count is zero
// ----------------------------------------------------------------------------
module dec_hold_counter_v #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            // A wrap from zero would silently stretch the phase by 2**CW cycles.
            assert (count != '0);
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/priority_dec_2_4_v.sv
// ----------------------------------------------------------------------------
// priority_dec_2_4_v
// Sequential 2-to-4 decoder: accepts a 2-bit code under valid/ready and drives
// the matching one-hot line for HOLD_CYCLES clocks, then keeps all lines low
// for GAP_CYCLES clocks before accepting the next code.
//
// Optional build macro PRIORITY_DEC_STICKY_EN: adds i_ack; the line is then
// held until a cycle with i_ack=1 in HOLD instead of for HOLD_CYCLES clocks.
//
// Parameters:
//   HOLD_CYCLES  cycles a decoded line stays asserted (1..255)
//   GAP_CYCLES   dead cycles after each hold (0..15)
//   CW           counter width, must hold max(HOLD_CYCLES, GAP_CYCLES)
// Ports:
//   i_clk        in   clock, rising edge
//   i_rst_n      in   asynchronous active-low reset
//   i_code       in   encoded index
//   i_valid      in   i_code is valid this cycle
//   i_ack        in   (sticky build only) release the held line
//   o_ready      out  decoder can accept a code (registered, state==IDLE)
//   o_line       out  one-hot decoded lines, all-zero outside HOLD
//   o_busy       out  state is HOLD or GAP
//   o_last_code  out  last accepted code
// ----------------------------------------------------------------------------
module priority_dec_2_4_v
    import pd_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CW          = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_code,
    input  logic        i_valid,
`ifdef PRIORITY_DEC_STICKY_EN
    input  logic        i_ack,
`endif
    output logic        o_ready,
    output logic [3:0]  o_line,
    output logic        o_busy,
    output logic [1:0]  o_last_code
);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    state_t        state;
    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt_val;
    logic          cnt_zero;
    logic          hold_done;

`ifdef PRIORITY_DEC_STICKY_EN
    assign hold_done = i_ack;
`else
    assign hold_done = cnt_zero;
`endif

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        unique case (state)
            IDLE: begin
                if (i_valid) begin
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    cnt_load = (GAP_CYCLES > 0);
                    cnt_val  = GAP_LOAD;
                end else begin
`ifdef PRIORITY_DEC_STICKY_EN
                    cnt_dec  = 1'b0;
`else
                    cnt_dec  = 1'b1;
`endif
                end
            end
            GAP: begin
                cnt_dec = !cnt_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_line      <= '0;
            o_last_code <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_last_code <= i_code;
                        o_line      <= onehot4(i_code);
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        o_line <= '0;
                        state  <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (cnt_zero) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: ready/busy are decodes of the state flop alone, so they are glitch-
    // free registered outputs with no combinational path from i_valid.
    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);

    dec_hold_counter_v #(.CW(CW)) u_counter (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

endmodule

// File: tb/tb_priority_dec_2_4_v.sv
// ----------------------------------------------------------------------------
// tb_priority_dec_2_4_v
// Two decoder instances (HOLD=4/GAP=1 and HOLD=1/GAP=0) share one stimulus.
// The reference model tracks, per instance, the accepting edge of the current
// code and the edges at which its line ends and ready returns, and derives the
// expected outputs from those edge numbers.
// ----------------------------------------------------------------------------
module tb_priority_dec_2_4_v;

`ifdef PRIORITY_DEC_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam int N   = 2;
    localparam int INF = 1 << 30;

    int hold_c [N] = '{4, 1};
    int gap_c  [N] = '{1, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] code;
    logic       valid;
    logic       ack;

    logic [3:0] line_o  [N];
    logic       ready_o [N];
    logic       busy_o  [N];
    logic [1:0] last_o  [N];

    int vectors     = 0;
    int miscompares = 0;

    // reference model state, in edge numbers
    int         k = 0;
    int         acc      [N];
    int         hold_end [N];
    int         ready_at [N];
    logic [1:0] m_last   [N];

    always #5 clk = ~clk;

    priority_dec_2_4_v #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CW(8)) u0 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_code      (code),
        .i_valid     (valid),
`ifdef PRIORITY_DEC_STICKY_EN
        .i_ack       (ack),
`endif
        .o_ready     (ready_o[0]),
        .o_line      (line_o[0]),
        .o_busy      (busy_o[0]),
        .o_last_code (last_o[0])
    );

    priority_dec_2_4_v #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CW(8)) u1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_code      (code),
        .i_valid     (valid),
`ifdef PRIORITY_DEC_STICKY_EN
        .i_ack       (ack),
`endif
        .o_ready     (ready_o[1]),
        .o_line      (line_o[1]),
        .o_busy      (busy_o[1]),
        .o_last_code (last_o[1])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            acc[i]      = -1000;
            hold_end[i] = -1000;
            ready_at[i] = -1;
            m_last[i]   = 2'b00;
        end
    endtask

    task automatic model_edge();
        bit ready_before;
        k++;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                ready_before = (k - 1 >= ready_at[i]);
                if (STICKY && ack && acc[i] <= k - 1 && k - 1 < hold_end[i]) begin
                    hold_end[i] = k;
                    ready_at[i] = k + gap_c[i];
                end
                if (ready_before && valid) begin
                    acc[i]    = k;
                    m_last[i] = code;
                    if (STICKY) begin
                        hold_end[i] = INF;
                        ready_at[i] = INF;
                    end else begin
                        hold_end[i] = k + hold_c[i];
                        ready_at[i] = hold_end[i] + gap_c[i];
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] exp_line;
        bit         exp_ready;
        for (int i = 0; i < N; i++) begin
            exp_line  = (acc[i] <= k && k < hold_end[i]) ? (4'b0001 << m_last[i]) : 4'b0000;
            exp_ready = (k >= ready_at[i]);
            check($sformatf("u%0d.line", i),  8'(line_o[i]),  8'(exp_line));
            check($sformatf("u%0d.ready", i), 8'(ready_o[i]), 8'(exp_ready));
            check($sformatf("u%0d.busy", i),  8'(busy_o[i]),  8'(!exp_ready));
            check($sformatf("u%0d.last", i),  8'(last_o[i]),  8'(m_last[i]));
            check($sformatf("u%0d.onehot", i), 8'($countones(line_o[i]) <= 1), 8'd1);
        end
    endtask

    // one clock: edge, model update, sample 1 ns later, return at the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        code  = 2'b00;
        ack   = 1'b0;
        model_reset();

        // reset state
        step();
        step();
        rst_n = 1'b1;
        step();
        check("reset.line", 8'(line_o[0]), 8'h00);
        check("reset.ready", 8'(ready_o[0]), 8'h01);

        // single accept of code 2, then X on i_code while invalid
        code  = 2'b10;
        valid = 1'b1;
        step();
        check("accept.line", 8'(line_o[0]), 8'h04);
        valid = 1'b0;
        code  = 2'bxx;
        repeat (8) step();
        check("accept.last", 8'(last_o[0]), 8'h02);

        // valid held high, code stepping each cycle
        valid = 1'b1;
        for (int j = 0; j < 24; j++) begin
            code = 2'(j);
            step();
        end
        valid = 1'b0;
        repeat (6) step();

        // async reset in the second cycle of HOLD
        code  = 2'b01;
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        check("midhold.line", 8'(line_o[0]), 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("async.line", 8'(line_o[0]), 8'h00);
        check("async.ready", 8'(ready_o[0]), 8'h01);
        step();
        rst_n = 1'b1;
        step();

`ifdef PRIORITY_DEC_STICKY_EN
        // sticky hold released by i_ack
        code  = 2'b01;
        valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (20) step();
        check("sticky.held", 8'(line_o[0]), 8'h02);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("sticky.release", 8'(line_o[0]), 8'h00);
        repeat (4) step();
`endif

        // randomized traffic
        repeat (400) begin
            valid = ($urandom_range(0, 3) != 0);
            code  = 2'($urandom);
            ack   = STICKY ? ($urandom_range(0, 7) == 0) : 1'b0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/priority_dec_2_4_v.md
Name: priority_dec_2_4_v

Overview:
- Sequential 2-to-4 decoder. It is the receive end of the (o_code, o_valid) pair produced by the 4-to-2 priority encoders.
- Accepts a 2-bit code under a valid/ready handshake. Drives the matching one-hot line for a programmable number of cycles, then returns the output to zero.
- Used to regenerate request/strobe lines from an encoded bus.

Parameters:
- HOLD_CYCLES, 4, cycles a decoded line stays asserted (legal range 1..255).
- GAP_CYCLES, 1, dead cycles with all lines low after each hold (legal range 0..15).
- CW, 8, width of the hold/gap counter; must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_code  in  2  encoded index to decode.
- i_valid  in  1  i_code is valid this cycle.
- o_ready  out  1  decoder can accept a code this cycle.
- o_line  out  4  one-hot decoded output; o_line[i_code] asserted during hold.
- o_busy  out  1  high in HOLD or GAP.
- o_last_code  out  2  last accepted code.

Behaviour:
- Clock and reset: one clock domain (i_clk). Reset is asynchronous, active-low (i_rst_n). All flops clear on assertion, independent of i_clk.
- Reset values: o_line=4'b0000, o_ready=1, o_busy=0, o_last_code=2'b00, state=IDLE, counter=0.
- Handshake: a transfer occurs on a rising edge where i_valid=1 and o_ready=1.
  - o_ready is a registered output and equals (state==IDLE).
  - No combinational path from i_valid to o_ready.
- FSM states: IDLE, HOLD, GAP.
  - IDLE: on transfer, latch i_code into o_last_code. Next cycle o_line = 1<<i_code (latency 1 cycle from accepting edge). Load counter=HOLD_CYCLES-1; go to HOLD.
  - HOLD: o_line held constant; i_code/i_valid ignored.
    - If counter==0: o_line<=0. If GAP_CYCLES>0, load counter=GAP_CYCLES-1 and go to GAP; else go to IDLE.
    - Otherwise decrement the counter.
  - GAP: o_line=0. If counter==0 go to IDLE, else decrement.
- Line timing: o_line is asserted for exactly HOLD_CYCLES clocks per accepted code.
- Throughput: minimum spacing between accepted codes is 1+HOLD_CYCLES+GAP_CYCLES cycles. With GAP_CYCLES=0 this is HOLD_CYCLES+1.
- o_line is never more than one-hot. It is all-zero outside HOLD.
- o_busy = (state!=IDLE), registered.
- Boundary cases:
  - i_valid held high continuously: one code accepted per IDLE visit. The code sampled is the one present on the accepting edge.
  - HOLD_CYCLES=1: single-cycle strobe.
  - Counter must never wrap. A decrement from 0 is illegal (assert in simulation).
  - Reset mid-HOLD or mid-GAP: o_line drops to 0 immediately (async). Returns to IDLE with o_ready=1 after deassertion.
  - i_code X/Z while i_valid=0: no effect.

Optional Feature:
- Macro: PRIORITY_DEC_STICKY_EN.
- Defined:
  - Adds input port i_ack (1 bit).
  - HOLD ignores the counter. o_line stays asserted until a cycle with i_ack=1, then proceeds to GAP/IDLE as above.
  - i_ack in IDLE or GAP is ignored.
  - i_ack on the same edge HOLD is entered is not counted (line lasts at least 1 cycle).
- Undefined: i_ack port absent; timed HOLD as described.

Decomposition:
- Shared package pd_pkg:
  - state enum (IDLE=2'd0, HOLD=2'd1, GAP=2'd2).
  - Localparam CODE_W=2, LINES=4.
  - Function onehot4(code) returning 4-bit one-hot.
- One natural sub-module: dec_hold_counter_v, a loadable down-counter with zero flag, width CW. It is used for both HOLD and GAP.

Test Plan:
1. Reset: i_rst_n=0 then release, i_valid=0 -> o_line=0000, o_ready=1, o_busy=0, o_last_code=00.
2. Defaults (HOLD=4, GAP=1): send i_code=2'b10 with i_valid=1 for one edge -> next cycle o_line=0100 for 4 cycles, then 0000. o_ready returns to 1 after 5 cycles in HOLD+GAP. o_last_code=10.
3. i_valid held high while i_code steps 0,1,2,3 each cycle -> only codes present on accepting edges decoded. Accepts spaced 6 cycles apart. o_line never has more than one bit set.
4. HOLD_CYCLES=1, GAP_CYCLES=0, i_code=2'b11 streamed -> o_line=1000 for 1 cycle, alternating with idle. Accept every 2 cycles.
5. Async reset asserted in cycle 2 of HOLD with o_line=0010 -> o_line=0000 before the next clock edge. o_ready=1 after release.
6. PRIORITY_DEC_STICKY_EN defined: accept i_code=2'b01, hold i_ack=0 for 20 cycles -> o_line=0010 throughout. Pulse i_ack -> o_line=0000 next cycle, then GAP, then IDLE.
